// File: rtl/riscv_ctrl_pkg.sv
// Shared control definitions for the sequential RV64 core: FSM state encodings
// and PC constants used by the sequencer and its next-PC selector.
package riscv_ctrl_pkg;

  localparam int          XLEN_DEF     = 64;
  localparam logic [63:0] RESET_PC_DEF = 64'h0;
  localparam logic [63:0] PC_STEP      = 64'd4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_HALT      = 3'd6
  } state_e;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection (JALR > JAL/taken branch > sequential) plus
// the 4-byte alignment check on the chosen target.
module pc_next_sel
  import riscv_ctrl_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] alu_result,
  input  logic            jump,
  input  logic            jalr,
  input  logic            branch,
  input  logic            zero,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  always_comb begin
    if (jalr) begin
      next_pc = alu_result & ~XLEN'(1);
    end else if (jump || (branch && zero)) begin
      // imm is in halfword units; the add wraps modulo 2^XLEN
      next_pc = pc + (imm << 1);
    end else begin
      next_pc = pc + XLEN'(PC_STEP);
    end
    misaligned = (next_pc[1:0] != 2'b00);
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK controller owning the PC.
// Optional performance counters are built only when PC_SEQ_PERF_CNT_EN is defined.
module pc_sequencer
  import riscv_ctrl_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  output logic            ir_we,
  input  logic            halt_req,
  input  logic            mem_access,
  output logic            dmem_req,
  input  logic            dmem_ack,
  input  logic            branch,
  input  logic            zero,
  input  logic            jump,
  input  logic            jalr,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] alu_result,
  output logic            wb_en,
  output logic [XLEN-1:0] pc,
  output logic [2:0]      state,
  output logic            halted,
  output logic            misalign_fault,
  output logic [63:0]     cycle_cnt,
  output logic [63:0]     instret_cnt
);

  state_e          r_state;
  state_e          w_state_next;
  logic [XLEN-1:0] r_pc;
  logic            r_ir_we;
  logic            r_fault;
  logic [XLEN-1:0] w_next_pc;
  logic            w_misaligned;

  pc_next_sel #(.XLEN(XLEN)) u_next_sel (
    .pc         (r_pc),
    .imm        (imm),
    .alu_result (alu_result),
    .jump       (jump),
    .jalr       (jalr),
    .branch     (branch),
    .zero       (zero),
    .next_pc    (w_next_pc),
    .misaligned (w_misaligned)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
      r_ir_we <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ir_we <= (r_state == ST_FETCH) && imem_ack;
      if (r_state == ST_WRITEBACK) begin
        // A misaligned target freezes the PC at the faulting instruction
        if (w_misaligned) begin
          r_fault <= 1'b1;
        end else begin
          r_pc <= w_next_pc;
        end
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:      if (start) w_state_next = ST_FETCH;
      ST_FETCH:     if (imem_ack) w_state_next = ST_DECODE;
      ST_DECODE:    w_state_next = halt_req ? ST_HALT : ST_EXECUTE;
      ST_EXECUTE:   w_state_next = mem_access ? ST_MEMORY : ST_WRITEBACK;
      ST_MEMORY:    if (dmem_ack) w_state_next = ST_WRITEBACK;
      ST_WRITEBACK: w_state_next = w_misaligned ? ST_HALT : ST_FETCH;
      ST_HALT:      w_state_next = ST_HALT;
      default:      w_state_next = ST_IDLE;
    endcase
  end

  assign imem_req       = (r_state == ST_FETCH);
  assign dmem_req       = (r_state == ST_MEMORY);
  assign wb_en          = (r_state == ST_WRITEBACK);
  assign halted         = (r_state == ST_HALT);
  assign ir_we          = r_ir_we;
  assign imem_addr      = r_pc;
  assign pc             = r_pc;
  assign state          = r_state;
  assign misalign_fault = r_fault;

`ifdef PC_SEQ_PERF_CNT_EN
  logic [63:0] r_cycle_cnt;
  logic [63:0] r_instret_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle_cnt   <= 64'd0;
      r_instret_cnt <= 64'd0;
    end else begin
      if ((r_state != ST_IDLE) && (r_state != ST_HALT)) begin
        r_cycle_cnt <= r_cycle_cnt + 64'd1;
      end
      if ((r_state == ST_WRITEBACK) && !w_misaligned) begin
        r_instret_cnt <= r_instret_cnt + 64'd1;
      end
    end
  end

  assign cycle_cnt   = r_cycle_cnt;
  assign instret_cnt = r_instret_cnt;
`else
  assign cycle_cnt   = 64'd0;
  assign instret_cnt = 64'd0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a per-instruction timing/PC model drives
// expectations that are compared every cycle, plus literal spot checks.
module tb_pc_sequencer;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2,
                         S_EXECUTE = 3'd3, S_MEMORY = 3'd4, S_WB = 3'd5,
                         S_HALT = 3'd6;
`ifdef PC_SEQ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start, imem_ack, halt_req, mem_access, dmem_ack;
  logic        branch, zero, jump, jalr;
  logic [63:0] imm, alu_result;
  logic        imem_req, ir_we, dmem_req, wb_en, halted, misalign_fault;
  logic [63:0] imem_addr, pc, cycle_cnt, instret_cnt;
  logic [2:0]  state;

  int n_vec = 0, n_err = 0, n_irwe = 0, n_wben = 0, n_dreq = 0;
  bit check_en = 1'b0;

  logic [2:0]  exp_state = S_IDLE;
  logic [63:0] exp_pc = 64'h0, exp_cyc = 64'h0, exp_inst = 64'h0;
  logic        exp_ir_we = 1'b0, exp_fault = 1'b0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .ir_we(ir_we), .halt_req(halt_req), .mem_access(mem_access),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .branch(branch), .zero(zero), .jump(jump), .jalr(jalr),
    .imm(imm), .alu_result(alu_result), .wb_en(wb_en), .pc(pc),
    .state(state), .halted(halted), .misalign_fault(misalign_fault),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk64("state", 64'(state), 64'(exp_state));
      chk64("pc", pc, exp_pc);
      chk64("imem_addr", imem_addr, exp_pc);
      chk1("imem_req", imem_req, exp_state == S_FETCH);
      chk1("dmem_req", dmem_req, exp_state == S_MEMORY);
      chk1("wb_en", wb_en, exp_state == S_WB);
      chk1("halted", halted, exp_state == S_HALT);
      chk1("ir_we", ir_we, exp_ir_we);
      chk1("misalign_fault", misalign_fault, exp_fault);
      chk64("cycle_cnt", cycle_cnt, PERF ? exp_cyc : 64'd0);
      chk64("instret_cnt", instret_cnt, PERF ? exp_inst : 64'd0);
      if (ir_we)    n_irwe++;
      if (wb_en)    n_wben++;
      if (dmem_req) n_dreq++;
    end
  end

  task automatic tick();
    bit act;
    act = (exp_state != S_IDLE) && (exp_state != S_HALT);
    @(posedge clk);
    #1;
    if (act) exp_cyc = exp_cyc + 64'd1;
  endtask

  task automatic clear_inputs();
    start = 0; imem_ack = 0; halt_req = 0; mem_access = 0; dmem_ack = 0;
    branch = 0; zero = 0; jump = 0; jalr = 0; imm = '0; alu_result = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_inputs();
    exp_state = S_IDLE; exp_pc = 64'h0; exp_cyc = 64'h0; exp_inst = 64'h0;
    exp_ir_we = 1'b0; exp_fault = 1'b0;
    check_en = 1'b1;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_state = S_FETCH;
  endtask

  // One instruction from its first FETCH cycle; iw/mw are wait cycles before each ack.
  task automatic run_instr(input bit halt, input bit mem, input int iw, input int mw,
                           input bit br, input bit zr, input bit jp, input bit jr,
                           input logic [63:0] immv, input logic [63:0] alu);
    logic [63:0] t;
    for (int w = 0; w <= iw; w++) begin
      imem_ack = (w == iw);
      tick();
    end
    imem_ack = 1'b0;
    exp_state = S_DECODE; exp_ir_we = 1'b1;
    halt_req = halt;
    tick();
    halt_req = 1'b0; exp_ir_we = 1'b0;
    if (halt) begin
      exp_state = S_HALT;
      return;
    end
    exp_state = S_EXECUTE;
    mem_access = mem;
    tick();
    mem_access = 1'b0;
    if (mem) begin
      exp_state = S_MEMORY;
      for (int w = 0; w <= mw; w++) begin
        dmem_ack = (w == mw);
        tick();
      end
      dmem_ack = 1'b0;
    end
    exp_state = S_WB;
    branch = br; zero = zr; jump = jp; jalr = jr; imm = immv; alu_result = alu;
    if (jr)                   t = {alu[63:1], 1'b0};
    else if (jp || (br && zr)) t = exp_pc + immv * 64'd2;
    else                      t = exp_pc + 64'd4;
    tick();
    branch = 0; zero = 0; jump = 0; jalr = 0; imm = '0; alu_result = '0;
    if (t[1:0] != 2'b00) begin
      exp_fault = 1'b1; exp_state = S_HALT;
    end else begin
      exp_pc = t; exp_inst = exp_inst + 64'd1; exp_state = S_FETCH;
    end
  endtask

  initial begin
    int p_ir, p_wb, p_dr;
    reset = 1'b1;
    clear_inputs();
    do_reset();
    imem_ack = 1'b1; dmem_ack = 1'b1;
    tick();
    imem_ack = 1'b0; dmem_ack = 1'b0;
    go();
    p_ir = n_irwe; p_wb = n_wben;
    run_instr(0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 64'h0);
    chk64("seq_pc", pc, 64'h4);
    chk64("ir_we_pulses", 64'(n_irwe - p_ir), 64'd1);
    chk64("wb_en_pulses", 64'(n_wben - p_wb), 64'd1);

    p_dr = n_dreq;
    run_instr(0, 1, 1, 2, 0, 0, 0, 0, 64'h0, 64'h0);
    chk64("load_dmem_req_cycles", 64'(n_dreq - p_dr), 64'd3);
    chk64("load_pc", pc, 64'h8);

    run_instr(0, 0, 0, 0, 0, 0, 0, 1, 64'h0, 64'h100);
    chk64("jalr_pc", pc, 64'h100);
    run_instr(0, 0, 0, 0, 1, 1, 0, 0, 64'd8, 64'h0);
    chk64("branch_taken_pc", pc, 64'h110);
    run_instr(0, 0, 0, 0, 0, 0, 0, 1, 64'h0, 64'h100);
    run_instr(0, 0, 0, 0, 1, 0, 0, 0, 64'd8, 64'h0);
    chk64("branch_not_taken_pc", pc, 64'h104);
    run_instr(0, 0, 0, 0, 0, 1, 0, 0, 64'd8, 64'h0);
    chk64("zero_without_branch_pc", pc, 64'h108);
    run_instr(0, 0, 2, 0, 0, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0);
    chk64("jal_negative_pc", pc, 64'h100);

    run_instr(0, 0, 0, 0, 0, 0, 0, 1, 64'h0, 64'h203);
    chk1("misalign_fault_set", misalign_fault, 1'b1);
    chk64("misalign_pc_held", pc, 64'h100);
    start = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1;
    repeat (3) tick();
    clear_inputs();
    chk1("halt_after_fault", halted, 1'b1);

    do_reset();
    go();
    run_instr(0, 0, 0, 0, 0, 0, 0, 1, 64'h0, 64'h205);
    chk64("jalr_lsb_clear_pc", pc, 64'h204);
    chk1("no_fault", misalign_fault, 1'b0);

    run_instr(0, 0, 0, 0, 0, 0, 0, 1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC);
    run_instr(0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 64'h0);
    chk64("wrap_pc", pc, 64'h0);

    run_instr(1, 0, 0, 0, 0, 0, 0, 0, 64'h0, 64'h0);
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    chk64("halt_req_state", 64'(state), 64'(S_HALT));

    do_reset();
    go();
    imem_ack = 1'b1;
    do_reset();
    chk1("reset_mid_fetch_ir_we", ir_we, 1'b0);
    chk64("reset_mid_fetch_state", 64'(state), 64'(S_IDLE));
    tick();

    go();
    repeat (3) run_instr(0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 64'h0);
    chk64("perf_cycle_cnt", cycle_cnt, PERF ? 64'd12 : 64'd0);
    chk64("perf_instret_cnt", instret_cnt, PERF ? 64'd3 : 64'd0);
    chk64("three_seq_pc", pc, 64'hC);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
